// File: rtl/xgmii_rx_parser.sv
// XGMII receive front end: validates Start/preamble/SFD, realigns lane-4
// starts onto 8-byte beats and emits payload beats (DA first, FCS kept)
// with sop/eop/keep/err qualifiers. No backpressure.
// Optional build macro XGMII_RX_STATS_EN adds frame_cnt/err_cnt outputs.
module xgmii_rx_parser #(
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic [7:0]  rx_keep,
  output logic        rx_err
`ifdef XGMII_RX_STATS_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt
`endif
);

  // Control characters of interest (Idle 0x07 and Error 0xFE need no
  // explicit decode: any flagged lane that is not Terminate is an error).
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE4 = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_TAIL = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  // Index of the lowest flagged lane, 8 when none.
  function automatic logic [3:0] first_ctl(input logic [7:0] c);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (c[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  // Contiguous byte mask with n bytes set, n in 0..8.
  function automatic logic [7:0] lane_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  logic [63:0]      rxd_q, rxd_d;
  logic [7:0]       rxc_q, rxc_d;
  logic [2:0]       state_q, state_d;
  logic             align_q, align_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_sop_q, rx_sop_d;
  logic        rx_eop_q, rx_eop_d;
  logic [7:0]  rx_keep_q, rx_keep_d;
  logic        rx_err_q, rx_err_d;

  logic             start_l0, start_l4, start_any, pre_ok, drop_exit;
  logic [63:0]      win_data;
  logic [7:0]       win_ctl;
  logic [3:0]       n, keep_n, tail_idx;
  logic [7:0]       ctl_byte;
  logic             term_here, bad_here, term_next, tail_go;
  logic [CNT_W:0]   room, n_ext;
  logic             trunc, over;
  logic             beat_eop, beat_err;
  logic [7:0]       beat_keep;
  logic             emit, pre_fail;

  // Input register: the registered word is decoded, the live word is lookahead.
  always_comb begin
    rxd_d = xgmii_rxd;
    rxc_d = xgmii_rxc;
  end

  // Start/preamble recognition and beat-window decode.
  always_comb begin
    start_l0  = (rxc_q == 8'h01) && (rxd_q == 64'hD555_5555_5555_55FB);
    start_l4  = (rxc_q[7:4] == 4'h1) && (rxd_q[39:32] == CH_START) &&
                (rxd_q[63:40] == 24'h55_5555);
    start_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rxc_q[i] && (rxd_q[8*i +: 8] == CH_START)) start_any = 1'b1;
    end
    pre_ok    = (rxc_q == 8'h00) && (rxd_q[31:0] == 32'hD555_5555);
    drop_exit = (rxc_q == 8'hFF) && !start_any;

    // align=4 window: upper half of registered word + lower half of live word
    win_data = align_q ? {xgmii_rxd[31:0], rxd_q[63:32]} : rxd_q;
    win_ctl  = align_q ? {xgmii_rxc[3:0], rxc_q[7:4]} : rxc_q;
    n        = first_ctl(win_ctl);
    ctl_byte = win_data[{n[2:0], 3'b000} +: 8];
    term_here = (n != 4'd8) && (ctl_byte == CH_TERM);
    bad_here  = (n != 4'd8) && (ctl_byte != CH_TERM);

    // Terminate in lane 0 of the next window closes a full beat now.
    term_next = (n == 4'd8) &&
                (align_q ? (xgmii_rxc[4] && (xgmii_rxd[39:32] == CH_TERM))
                         : (xgmii_rxc[0] && (xgmii_rxd[7:0] == CH_TERM)));

    // Terminate in lanes 5..7 of the live word leaves 1..3 bytes for a tail beat.
    tail_idx = first_ctl({xgmii_rxc[7:5], 5'b0_0000});
    tail_go  = !xgmii_rxc[4] && (tail_idx != 4'd8) &&
               (xgmii_rxd[{tail_idx[2:0], 3'b000} +: 8] == CH_TERM);

    // Oversize: cnt_q stays below MAX_LEN while a frame is open.
    room   = (CNT_W+1)'(MAX_LEN) - {1'b0, cnt_q};
    n_ext  = (CNT_W+1)'(n);
    trunc  = room < n_ext;
    over   = trunc || ((room == n_ext) && !term_here && !term_next);
    keep_n = trunc ? room[3:0] : n;

    beat_eop  = term_here || bad_here || term_next || over;
    beat_err  = bad_here || over;
    beat_keep = lane_mask(keep_n);
  end

  // Frame FSM: next state, alignment, sop flag and byte count.
  always_comb begin
    state_d  = state_q;
    align_d  = align_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    pre_fail = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_l0) begin
          state_d = ST_DATA;
          align_d = 1'b0;
          first_d = 1'b1;
          cnt_d   = '0;
        end else if (start_l4) begin
          state_d = ST_PRE4;
          align_d = 1'b1;
          first_d = 1'b1;
          cnt_d   = '0;
        end else if (start_any) begin
          state_d  = ST_DROP;
          pre_fail = 1'b1;
        end
      end
      // The preamble word also carries payload bytes 0..3, so a pass emits.
      ST_PRE4: begin
        if (pre_ok) begin
          emit = 1'b1;
        end else begin
          state_d  = ST_DROP;
          pre_fail = 1'b1;
        end
      end
      ST_DATA, ST_TAIL: emit = 1'b1;
      ST_DROP: begin
        if (drop_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      first_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(8);
      if (beat_err)                 state_d = ST_DROP;
      else if (beat_eop)            state_d = ST_IDLE;
      else if (align_q && tail_go)  state_d = ST_TAIL;
      else                          state_d = ST_DATA;
    end
  end

  // Output beat: zero when idle so the stream is clean between frames.
  always_comb begin
    rx_valid_d = emit;
    rx_data_d  = emit ? win_data : 64'd0;
    rx_keep_d  = emit ? beat_keep : 8'd0;
    rx_sop_d   = emit && first_q;
    rx_eop_d   = emit && beat_eop;
    rx_err_d   = emit && beat_err;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_q      <= 64'd0;
      rxc_q      <= 8'd0;
      state_q    <= ST_IDLE;
      align_q    <= 1'b0;
      first_q    <= 1'b0;
      cnt_q      <= '0;
      rx_data_q  <= 64'd0;
      rx_valid_q <= 1'b0;
      rx_sop_q   <= 1'b0;
      rx_eop_q   <= 1'b0;
      rx_keep_q  <= 8'd0;
      rx_err_q   <= 1'b0;
    end else begin
      rxd_q      <= rxd_d;
      rxc_q      <= rxc_d;
      state_q    <= state_d;
      align_q    <= align_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_sop_q   <= rx_sop_d;
      rx_eop_q   <= rx_eop_d;
      rx_keep_q  <= rx_keep_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_sop   = rx_sop_q;
  assign rx_eop   = rx_eop_q;
  assign rx_keep  = rx_keep_q;
  assign rx_err   = rx_err_q;

`ifdef XGMII_RX_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  // Good frames count on a clean eop; errors on preamble failures and err-eops.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {31'd0, emit && beat_eop && !beat_err};
    err_cnt_d   = err_cnt_q + {31'd0, pre_fail || (emit && beat_err)};
  end

  // Statistics registers, wrapping at 2^32.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_q <= 32'd0;
      err_cnt_q   <= 32'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  // Without statistics the failure strobe has no consumer.
  logic stats_unused;
  assign stats_unused = pre_fail;
`endif

endmodule

// File: tb/tb_xgmii_rx_parser.sv
// Directed bench for xgmii_rx_parser: builds XGMII byte streams, captures
// output beats and compares them against hand-derived frame expectations.
module tb_xgmii_rx_parser;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] rx_data;
  logic        rx_valid, rx_sop, rx_eop, rx_err;
  logic [7:0]  rx_keep;
`ifdef XGMII_RX_STATS_EN
  logic [31:0] frame_cnt, err_cnt;
`endif

  xgmii_rx_parser dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .xgmii_rxd (xgmii_rxd),
    .xgmii_rxc (xgmii_rxc),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sop    (rx_sop),
    .rx_eop    (rx_eop),
    .rx_keep   (rx_keep),
    .rx_err    (rx_err)
`ifdef XGMII_RX_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int first_cyc = 0;
  int exp_frames = 0;
  int exp_errs = 0;

  logic [63:0] mon_data[$];
  logic [7:0]  mon_keep[$];
  logic [2:0]  mon_flg[$];
  int          mon_cyc[$];
  logic [7:0]  sb[$];
  bit          sc[$];

  // Beat capture away from the active edge.
  always @(negedge sys_clk) begin
    if (rx_valid === 1'b1) begin
      mon_data.push_back(rx_data);
      mon_keep.push_back(rx_keep);
      mon_flg.push_back({rx_sop, rx_eop, rx_err});
      mon_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_keep.delete();
    mon_flg.delete();
    mon_cyc.delete();
  endtask

  task automatic push(input logic [7:0] b, input bit c);
    sb.push_back(b);
    sc.push_back(c);
  endtask

  // Byte stream: [4 idles if lane-4] FB 55x6 SFD payload FD idles...
  task automatic build(input int align, input int n, input logic [7:0] sfd, input int err_idx);
    sb.delete();
    sc.delete();
    if (align != 0) repeat (4) push(8'h07, 1'b1);
    push(8'hFB, 1'b1);
    repeat (6) push(8'h55, 1'b0);
    push(sfd, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == err_idx) push(8'hFE, 1'b1);
      else              push(i[7:0], 1'b0);
    end
    push(8'hFD, 1'b1);
    while (sb.size() % 8 != 0) push(8'h07, 1'b1);
    repeat (24) push(8'h07, 1'b1);
  endtask

  task automatic send_stream(input int limit);
    int nw;
    nw = sb.size() / 8;
    if (limit < nw) nw = limit;
    for (int w = 0; w < nw; w++) begin
      logic [63:0] d;
      logic [7:0]  c;
      for (int j = 0; j < 8; j++) begin
        d[8*j +: 8] = sb[8*w + j];
        c[j]        = sc[8*w + j];
      end
      @(negedge sys_clk);
      xgmii_rxd = d;
      xgmii_rxc = c;
      if (w == 1) first_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      xgmii_rxd = 64'h0707_0707_0707_0707;
      xgmii_rxc = 8'hFF;
    end
  endtask

  task automatic run(input int align, input int n, input logic [7:0] sfd, input int err_idx);
    clear_mon();
    build(align, n, sfd, err_idx);
    send_stream(1 << 30);
    idle(2);
  endtask

  // Expected frame: nb beats of bytes 0,1,2..., last beat has last_kb bytes.
  task automatic check_frame(input string tag, input int nb, input int last_kb, input bit last_err);
    int got_n;
    got_n = mon_data.size();
    check({tag, "_beats"}, 64'(got_n), 64'(nb));
    for (int b = 0; b < nb && b < got_n; b++) begin
      int          kb;
      logic [63:0] ed, m;
      logic [8:0]  ek;
      kb = (b == nb - 1) ? last_kb : 8;
      ed = 64'd0;
      m  = 64'd0;
      for (int j = 0; j < kb; j++) begin
        int v;
        v = 8*b + j;
        ed[8*j +: 8] = v[7:0];
        m[8*j +: 8]  = 8'hFF;
      end
      ek = (9'd1 << kb) - 9'd1;
      check($sformatf("%s_b%0d_keep", tag, b), {56'd0, mon_keep[b]}, {56'd0, ek[7:0]});
      check($sformatf("%s_b%0d_data", tag, b), mon_data[b] & m, ed);
      check($sformatf("%s_b%0d_flags", tag, b), {61'd0, mon_flg[b]},
            {61'd0, (b == 0), (b == nb - 1), ((b == nb - 1) && last_err)});
    end
    if (got_n > 0) check({tag, "_latency"}, 64'(mon_cyc[0] - first_cyc), 64'd2);
    $display("frame %s: beats=%0d", tag, got_n);
  endtask

  task automatic check_stats(input string tag);
`ifdef XGMII_RX_STATS_EN
    check({tag, "_frame_cnt"}, {32'd0, frame_cnt}, 64'(exp_frames));
    check({tag, "_err_cnt"}, {32'd0, err_cnt}, 64'(exp_errs));
`else
    $display("%s: model frames=%0d errs=%0d", tag, exp_frames, exp_errs);
`endif
  endtask

  task automatic check_dropped(input string tag);
    check({tag, "_beats"}, 64'(mon_data.size()), 64'd0);
    $display("frame %s: beats=%0d", tag, mon_data.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    xgmii_rxd = 64'h0707_0707_0707_0707;
    xgmii_rxc = 8'hFF;
    repeat (3) @(negedge sys_clk);
    check("rst_valid", {63'd0, rx_valid}, 64'd0);
    check("rst_data", rx_data, 64'd0);
    check("rst_keep", {56'd0, rx_keep}, 64'd0);
    check("rst_flags", {61'd0, rx_sop, rx_eop, rx_err}, 64'd0);
    check_stats("rst");
    sys_rst_n = 1'b1;
    idle(3);

    run(0, 64, 8'hD5, -1);   check_frame("l0_64", 8, 8, 1'b0);  exp_frames++; check_stats("l0_64");
    run(1, 60, 8'hD5, -1);   check_frame("l4_60", 8, 4, 1'b0);  exp_frames++; check_stats("l4_60");
    run(1, 64, 8'hD5, -1);   check_frame("l4_64", 8, 8, 1'b0);  exp_frames++; check_stats("l4_64");
    run(0, 61, 8'hD5, -1);   check_frame("l0_61", 8, 5, 1'b0);  exp_frames++; check_stats("l0_61");
    run(1, 65, 8'hD5, -1);   check_frame("l4_65", 9, 1, 1'b0);  exp_frames++; check_stats("l4_65");
    run(0, 40, 8'hD4, -1);   check_dropped("l0_badsfd");        exp_errs++;   check_stats("l0_badsfd");
    run(1, 40, 8'hD4, -1);   check_dropped("l4_badsfd");        exp_errs++;   check_stats("l4_badsfd");
    run(0, 64, 8'hD5, 18);   check_frame("err_ln2", 3, 2, 1'b1); exp_errs++;  check_stats("err_ln2");
    run(0, 64, 8'hD5, -1);   check_frame("post_err", 8, 8, 1'b0); exp_frames++; check_stats("post_err");
    run(0, 1518, 8'hD5, -1); check_frame("len_max", 190, 6, 1'b0); exp_frames++; check_stats("len_max");
    run(0, 1530, 8'hD5, -1); check_frame("oversize", 190, 6, 1'b1); exp_errs++; check_stats("oversize");

    // Reset pulse while beats are flowing.
    clear_mon();
    build(0, 64, 8'hD5, -1);
    send_stream(5);
    @(posedge sys_clk);
    #2;
    check("pre_rst_valid", {63'd0, rx_valid}, 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, rx_valid}, 64'd0);
    check("mid_rst_data", rx_data, 64'd0);
    check("mid_rst_keep", {56'd0, rx_keep}, 64'd0);
    check("mid_rst_flags", {61'd0, rx_sop, rx_eop, rx_err}, 64'd0);
    exp_frames = 0;
    exp_errs = 0;
    check_stats("mid_rst");
    idle(2);
    sys_rst_n = 1'b1;
    idle(3);
    run(0, 64, 8'hD5, -1);   check_frame("post_rst", 8, 8, 1'b0); exp_frames++; check_stats("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
